// File: rtl/lsu_axi_bridge.sv
// LSU-to-AXI4-Lite bridge: one outstanding load or store, byte-lane alignment from addr[1:0],
// one-cycle completion pulse back to the LSU with right-justified load data.
module lsu_axi_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic              lsu_arvalid,
   input  logic [7:0]        lsu_rstrb,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_rvalid,
   input  logic [ADDR_W-1:0] lsu_awaddr,
   input  logic              lsu_awvalid,
   input  logic              lsu_wvalid,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wstrb,
   output logic              lsu_wready,
   output logic              lsu_err,
   output logic [ADDR_W-1:0] m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [DATA_W-1:0] m_wdata,
   output logic [3:0]        m_wstrb,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [1:0]        m_bresp,
   input  logic              m_bvalid,
   output logic              m_bready
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

   state_t            state;
   logic              skip;
   logic [1:0]        offset;
   logic [1:0]        size;
   logic [DATA_W-1:0] rd_shift;
   logic [DATA_W-1:0] rd_data;
   logic [3:0]        st_strb;

   // Unsupported strobe encodings are reported exactly like misaligned accesses.
   function automatic logic bad_access(input logic [7:0] strb, input logic [1:0] lo);
      case (strb)
         8'h01:   bad_access = 1'b0;
         8'h03:   bad_access = lo[0];
         8'h0f:   bad_access = (lo != 2'b00);
         default: bad_access = 1'b1;
      endcase
   endfunction

   always_comb begin
      rd_shift = m_rdata >> {offset, 3'b000};
      case (size)
         2'd0:    rd_data = {{(DATA_W-8){1'b0}}, rd_shift[7:0]};
         2'd1:    rd_data = {{(DATA_W-16){1'b0}}, rd_shift[15:0]};
         default: rd_data = rd_shift;
      endcase
      st_strb = lsu_wstrb[3:0] << lsu_awaddr[1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         skip       <= 1'b0;
         offset     <= 2'd0;
         size       <= 2'd0;
         lsu_rdata  <= '0;
         lsu_rvalid <= 1'b0;
         lsu_wready <= 1'b0;
         lsu_err    <= 1'b0;
         m_araddr   <= '0;
         m_arvalid  <= 1'b0;
         m_rready   <= 1'b0;
         m_awaddr   <= '0;
         m_awvalid  <= 1'b0;
         m_wdata    <= '0;
         m_wstrb    <= 4'd0;
         m_wvalid   <= 1'b0;
         m_bready   <= 1'b0;
      end else begin
         lsu_rvalid <= 1'b0;
         lsu_wready <= 1'b0;
         lsu_err    <= 1'b0;
         case (state)
            IDLE: begin
               // The request seen in the first IDLE cycle after DONE is the one just completed.
               skip <= 1'b0;
               if (!skip) begin
                  if (lsu_awvalid && lsu_wvalid) begin
                     if (bad_access(lsu_wstrb, lsu_awaddr[1:0])) begin
                        lsu_wready <= 1'b1;
                        lsu_err    <= 1'b1;
                        state      <= DONE;
                     end else begin
                        m_awaddr  <= {lsu_awaddr[ADDR_W-1:2], 2'b00};
                        m_wdata   <= lsu_wdata << {lsu_awaddr[1:0], 3'b000};
                        m_wstrb   <= st_strb;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= WR_AW;
                     end
                  end else if (lsu_arvalid) begin
                     if (bad_access(lsu_rstrb, lsu_araddr[1:0])) begin
                        lsu_rvalid <= 1'b1;
                        lsu_err    <= 1'b1;
                        lsu_rdata  <= '0;
                        state      <= DONE;
                     end else begin
                        m_araddr  <= {lsu_araddr[ADDR_W-1:2], 2'b00};
                        offset    <= lsu_araddr[1:0];
                        size      <= (lsu_rstrb == 8'h01) ? 2'd0 :
                                     (lsu_rstrb == 8'h03) ? 2'd1 : 2'd2;
                        m_arvalid <= 1'b1;
                        state     <= RD_A;
                     end
                  end
               end
            end
            RD_A: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  state     <= RD_D;
               end
            end
            RD_D: begin
               if (m_rvalid) begin
                  m_rready   <= 1'b0;
                  lsu_rdata  <= rd_data;
                  lsu_err    <= (m_rresp != 2'b00);
                  lsu_rvalid <= 1'b1;
                  state      <= DONE;
               end
            end
            WR_AW: begin
               // AW and W retire independently; a dropped valid means that channel is done.
               if (m_awready) m_awvalid <= 1'b0;
               if (m_wready)  m_wvalid  <= 1'b0;
               if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                  m_bready <= 1'b1;
                  state    <= WR_B;
               end
            end
            WR_B: begin
               if (m_bvalid) begin
                  m_bready   <= 1'b0;
                  lsu_err    <= (m_bresp != 2'b00);
                  lsu_wready <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               skip  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
